// File: rtl/issue_queue.sv
// In-order dual-lane issue queue between decode and issue stages.
// Circular buffer with up to two enqueues and two dequeues per cycle,
// whole-queue flush, and a sticky protocol-violation flag.
module issue_queue #(
  parameter  int unsigned DATA_W = 64,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush_i,
  input  logic [1:0]          in_valid_i,
  input  logic [2*DATA_W-1:0] in_data_i,
  output logic                allowin_o,
  output logic [1:0]          out_valid_o,
  output logic [2*DATA_W-1:0] out_data_o,
  input  logic [1:0]          deq_cnt_i,
  output logic [PTR_W:0]      count_o,
  output logic                error_o
);

  localparam int unsigned CW = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              error_q, error_d;

  logic              allowin;
  logic              enq_fire;
  logic [1:0]        n_in;
  logic [1:0]        n_out;
  logic [PTR_W-1:0]  wr_ptr_p1;
  logic [PTR_W-1:0]  rd_ptr_p1;

  // Space check uses registered occupancy only; same-cycle dequeue cannot raise it.
  assign allowin   = (count_q <= CW'(DEPTH - 2));
  assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
  assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);

  // Next-state computation for pointers, occupancy and the sticky error flag.
  always_comb begin
    enq_fire = allowin & in_valid_i[0] & ~flush_i;
    n_in     = '0;
    if (enq_fire) n_in = {1'b0, in_valid_i[0]} + {1'b0, in_valid_i[1]};

    n_out = '0;
    if (deq_cnt_i != 2'd3 && CW'(deq_cnt_i) <= count_q) n_out = deq_cnt_i;

    rd_ptr_d = rd_ptr_q + PTR_W'(n_out);
    wr_ptr_d = wr_ptr_q + PTR_W'(n_in);
    count_d  = count_q + CW'(n_in) - CW'(n_out);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end

    error_d = error_q;
    if (in_valid_i == 2'b10)                         error_d = 1'b1;
    if (in_valid_i != 2'b00 && !allowin && !flush_i) error_d = 1'b1;
    if (CW'(deq_cnt_i) > count_q)                    error_d = 1'b1;
    if (deq_cnt_i == 2'd3)                           error_d = 1'b1;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

  // Entry storage; lane 1 only lands when lane 0 is enqueued alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (enq_fire) begin
      mem_q[wr_ptr_q] <= in_data_i[DATA_W-1:0];
      if (in_valid_i[1]) mem_q[wr_ptr_p1] <= in_data_i[2*DATA_W-1:DATA_W];
    end
  end

  // Output presentation of the two oldest entries.
  always_comb begin
    allowin_o   = allowin;
    out_valid_o = {count_q >= CW'(2), count_q != '0};
    out_data_o  = {mem_q[rd_ptr_p1], mem_q[rd_ptr_q]};
    count_o     = count_q;
    error_o     = error_q;
  end

endmodule

// File: doc/issue_queue.md
# issue_queue

Parametrised in-order issue queue between decode (DS) and issue (IS) stages. Generalises the single-lane launch FIFO to a configurable depth and data width. Accepts up to two decoded instructions per cycle and presents up to two oldest entries per cycle for dual issue. Supports whole-queue flush on branch redirect/exception and flags protocol violations on a sticky error output.

## Interface
- DATA_W, 64: width of one decoded-instruction bus entry.
- DEPTH, 8: number of entries; power of two, minimum 4.
- PTR_W, $clog2(DEPTH): pointer width (derived, not overridden).

- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush_i  in  1  discard all entries (branch redirect / exception).
- in_valid_i  in  2  per-lane enqueue valid; lane 0 is older.
- in_data_i  in  2*DATA_W  lane 0 in [DATA_W-1:0], lane 1 in [2*DATA_W-1:DATA_W].
- allowin_o  out  1  queue can accept two entries this cycle.
- out_valid_o  out  2  bit0: ≥1 entry held; bit1: ≥2 entries held.
- out_data_o  out  2*DATA_W  lane 0 = oldest entry, lane 1 = second oldest.
- deq_cnt_i  in  2  entries consumed this cycle (0, 1 or 2).
- count_o  out  PTR_W+1  current occupancy, 0..DEPTH.
- error_o  out  1  sticky protocol-violation flag.

## Operation
- Storage: circular buffer mem[DEPTH], rd_ptr, wr_ptr (PTR_W bits, wrap modulo DEPTH), count (PTR_W+1 bits).
- allowin_o = (DEPTH − count) ≥ 2, computed from registered count only; a same-cycle dequeue does not raise it.
- Enqueue fires when allowin_o & in_valid_i[0] & !flush_i. Enqueued count n_in = in_valid_i[0] + in_valid_i[1]; lane 0 is written at wr_ptr, lane 1 at wr_ptr+1; wr_ptr += n_in.
- Dequeue: n_out = deq_cnt_i when deq_cnt_i ≤ count and deq_cnt_i ≠ 3, else 0; rd_ptr += n_out.
- count_next = count + n_in − n_out; simultaneous enqueue and dequeue are legal in every combination.
- out_data_o lane 0 = mem[rd_ptr], lane 1 = mem[rd_ptr+1] (wraps). Lane data is don't-care when the matching out_valid_o bit is 0.
- flush_i has priority over everything: next cycle rd_ptr = wr_ptr = 0 and count = 0. Same-cycle enqueue and dequeue are dropped. error_o is not cleared.
- error_o sets and holds until reset on any of these conditions:
  - in_valid_i == 2'b10;
  - in_valid_i ≠ 0 while !allowin_o and !flush_i;
  - deq_cnt_i > count;
  - deq_cnt_i == 3.
- Illegal requests never corrupt state. Rejected enqueues are not written. Illegal dequeues are ignored.

## Timing
- Reset values: allowin_o = 1, out_valid_o = 2'b00, out_data_o = 0 (mem cleared), count_o = 0, error_o = 0.
- Enqueue-to-visible latency is 1 cycle: data written at edge N appears on out_data_o after edge N, with no DS→IS bypass.
- Dequeue takes effect at the edge; the next entries are presented in the following cycle.
- Full: count == DEPTH gives allowin_o = 0. count == DEPTH−1 also gives allowin_o = 0 (two-slot rule).
- Empty: out_valid_o = 0; deq_cnt_i = 1 or 2 sets error_o.
- Pointer wrap: pointers wrap from DEPTH−1 to 0. A two-lane write or read straddling the wrap is legal.
- Reset asserted mid-operation clears state immediately, independent of clk.

## Test plan
- Reset, then enqueue in_valid_i=11 with data A, B → next cycle count_o=2, out_valid_o=11, out_data_o={B,A}, allowin_o=1.
- Enqueue 2 per cycle with deq_cnt_i=0 for 4 cycles at DEPTH=8 → count_o=8, allowin_o=0. A further in_valid_i=01 → error_o=1 and count stays 8.
- Fill to 6, then apply in_valid_i=11 with deq_cnt_i=2 in the same cycle → count_o=6 and order preserved. Continue for 10 cycles so pointers wrap at entry 7→0; out_data_o stays in FIFO order.
- Count 5, flush_i=1 together with in_valid_i=11 and deq_cnt_i=1 → next cycle count_o=0, out_valid_o=00, allowin_o=1, error_o unchanged.
- Count 1, deq_cnt_i=2 → error_o=1 and count stays 1. Separately, in_valid_i=10 from reset → error_o=1 and count stays 0.
- Assert reset asynchronously mid-cycle with count=3 and error_o=1 → outputs return to reset values before the next clk edge.
